// File: rtl/tile_pixel_gen.sv
// Tile/character pixel generator: fetches map, attribute and pattern bytes through one
// synchronous RAM read port and emits one colour index per pixel_en with 4-clk latency.
// Optional define TILE_SCROLL_EN adds scroll_x/scroll_y inputs with map-size wraparound.
module tile_pixel_gen #(
  parameter int unsigned       ADDR_W    = 15,
  parameter logic [ADDR_W-1:0] MAP_BASE  = 15'h0000,
  parameter logic [ADDR_W-1:0] ATTR_BASE = 15'h2000,
  parameter logic [ADDR_W-1:0] PAT_BASE  = 15'h4000,
  parameter int unsigned       MAP_COLS  = 80,
  parameter int unsigned       MAP_ROWS  = 60,
  parameter int unsigned       H_ACTIVE  = 640,
  parameter int unsigned       V_ACTIVE  = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_en,
  input  logic [9:0]        cycle,
  input  logic [8:0]        scanline,
`ifdef TILE_SCROLL_EN
  input  logic [9:0]        scroll_x,
  input  logic [8:0]        scroll_y,
`endif
  input  logic [7:0]        mem_rd_data,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [7:0]        pixel_data,
  output logic              pixel_valid,
  output logic              busy,
  output logic              overrun
);

  // The map must cover the whole visible area, otherwise tiles would repeat on screen.
  if (MAP_COLS * 8 < H_ACTIVE || MAP_ROWS * 8 < V_ACTIVE) begin : g_map_size_check
    $error("tile map smaller than the active area");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAPA = 3'd1,
    MAPD = 3'd2,
    ATTD = 3'd3,
    PATD = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [2:0]        xi_q, xi_d;
  logic [2:0]        yi_q, yi_d;
  logic              active_q, active_d;
  logic [7:0]        attr_q, attr_d;
  logic [7:0]        pix_q, pix_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  logic [31:0]       ex_w, ey_w, idx_w;
  logic              active_w;
  logic              pat_on;

  // Effective coordinates and map index for the pixel presented on the inputs.
  always_comb begin
`ifdef TILE_SCROLL_EN
    ex_w = (32'(cycle) + 32'(scroll_x)) % (MAP_COLS * 8);
    ey_w = (32'(scanline) + 32'(scroll_y)) % (MAP_ROWS * 8);
`else
    ex_w = 32'(cycle);
    ey_w = 32'(scanline);
`endif
    idx_w    = (ey_w >> 3) * MAP_COLS + (ex_w >> 3);
    // The active-area test deliberately ignores scrolling.
    active_w = (32'(cycle) < H_ACTIVE) && (32'(scanline) < V_ACTIVE);
  end

  assign pat_on = mem_rd_data[3'd7 - xi_q];

  // NOTE: every signal gets a default before the case so no path leaves one unassigned
  // (which would infer a latch); holding state means assigning the _q value explicitly.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    xi_d      = xi_q;
    yi_d      = yi_q;
    active_d  = active_q;
    attr_d    = attr_q;
    pix_d     = pix_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q | (pixel_en && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (pixel_en) begin
          state_d  = MAPA;
          idx_d    = ADDR_W'(idx_w);
          xi_d     = ex_w[2:0];
          yi_d     = ey_w[2:0];
          active_d = active_w;
          if (active_w) addr_d = MAP_BASE + ADDR_W'(idx_w);
        end
      end
      MAPA: begin
        state_d = MAPD;
        if (active_q) addr_d = ATTR_BASE + idx_q;
      end
      MAPD: begin
        // Tile number arrives now; it is consumed directly to form the pattern address.
        state_d = ATTD;
        if (active_q) addr_d = PAT_BASE + ADDR_W'({mem_rd_data, 3'b000}) + ADDR_W'(yi_q);
      end
      ATTD: begin
        state_d = PATD;
        attr_d  = mem_rd_data;
      end
      PATD: begin
        state_d = IDLE;
        valid_d = 1'b1;
        if (!active_q)   pix_d = 8'h00;
        else if (pat_on) pix_d = {4'h0, attr_q[7:4]};
        else             pix_d = {4'h0, attr_q[3:0]};
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values; datapath registers are reset too so a mid-fetch reset leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      xi_q      <= '0;
      yi_q      <= '0;
      active_q  <= 1'b0;
      attr_q    <= '0;
      pix_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      xi_q      <= xi_d;
      yi_q      <= yi_d;
      active_q  <= active_d;
      attr_q    <= attr_d;
      pix_q     <= pix_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign mem_rd_addr = addr_q;
  assign pixel_data  = pix_q;
  assign pixel_valid = valid_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_tile_pixel_gen.sv
// Self-checking bench for tile_pixel_gen: directed cases plus randomized pixels checked
// against a behavioural model of the tile map / attribute / pattern lookup.
module tb_tile_pixel_gen;

  localparam int MAP_BASE  = 'h0000;
  localparam int ATTR_BASE = 'h2000;
  localparam int PAT_BASE  = 'h4000;
  localparam int MAP_COLS  = 80;
  localparam int MAP_ROWS  = 60;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int RAM_SIZE  = 32768;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_en;
  logic [9:0]  cycle;
  logic [8:0]  scanline;
  logic [7:0]  mem_rd_data;
  logic [14:0] mem_rd_addr;
  logic [7:0]  pixel_data;
  logic        pixel_valid;
  logic        busy;
  logic        overrun;
`ifdef TILE_SCROLL_EN
  logic [9:0]  scroll_x;
  logic [8:0]  scroll_y;
`endif

  logic [7:0]  ram [0:RAM_SIZE-1];

  int          errors = 0;
  int          checks = 0;
  logic [14:0] exp_addr;
  logic [7:0]  exp_pix;

  typedef struct {
    bit          active;
    logic [14:0] map_a;
    logic [14:0] attr_a;
    logic [14:0] pat_a;
    logic [7:0]  pix;
  } exp_t;

  tile_pixel_gen dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_en    (pixel_en),
    .cycle       (cycle),
    .scanline    (scanline),
`ifdef TILE_SCROLL_EN
    .scroll_x    (scroll_x),
    .scroll_y    (scroll_y),
`endif
    .mem_rd_data (mem_rd_data),
    .mem_rd_addr (mem_rd_addr),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: address seen at edge E+1 returns data for the DUT to sample at E+2.
  always @(posedge clk) mem_rd_data <= ram[mem_rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what the pixel at raw (x,y) should look like, from the tile rules directly.
  function automatic exp_t model(input int x, input int y);
    exp_t        r;
    int          ex, ey, idx, tile, attr;
    logic [7:0]  pat;
    ex = x;
    ey = y;
`ifdef TILE_SCROLL_EN
    ex = (x + int'(scroll_x)) % (MAP_COLS * 8);
    ey = (y + int'(scroll_y)) % (MAP_ROWS * 8);
`endif
    r.active = (x < H_ACTIVE) && (y < V_ACTIVE);
    idx      = (ey / 8) * MAP_COLS + ex / 8;
    r.map_a  = 15'((MAP_BASE + idx) % RAM_SIZE);
    r.attr_a = 15'((ATTR_BASE + idx) % RAM_SIZE);
    tile     = int'(ram[r.map_a]);
    attr     = int'(ram[r.attr_a]);
    r.pat_a  = 15'((PAT_BASE + tile * 8 + ey % 8) % RAM_SIZE);
    pat      = ram[r.pat_a];
    if (!r.active)          r.pix = 8'h00;
    else if (pat[7 - ex % 8]) r.pix = 8'(attr / 16);
    else                    r.pix = 8'(attr % 16);
    return r;
  endfunction

  // One complete, undisturbed pixel transaction with per-cycle address/valid checks.
  task automatic do_pixel(input int x, input int y);
    exp_t e;
    e = model(x, y);
    check("idle_before", busy, 0);
    pixel_en = 1'b1;
    cycle    = 10'(x);
    scanline = 9'(y);
    tick();
    pixel_en = 1'b0;
    if (e.active) exp_addr = e.map_a;
    check("addr_map", mem_rd_addr, exp_addr);
    check("busy_t0", busy, 1);
    check("valid_t0", pixel_valid, 0);
    tick();
    if (e.active) exp_addr = e.attr_a;
    check("addr_attr", mem_rd_addr, exp_addr);
    tick();
    if (e.active) exp_addr = e.pat_a;
    check("addr_pat", mem_rd_addr, exp_addr);
    tick();
    check("addr_hold_t3", mem_rd_addr, exp_addr);
    check("valid_t3", pixel_valid, 0);
    check("pix_hold", pixel_data, exp_pix);
    tick();
    exp_pix = e.pix;
    check("valid_t4", pixel_valid, 1);
    check("pix", pixel_data, exp_pix);
    check("busy_t4", busy, 0);
    check("addr_hold_t4", mem_rd_addr, exp_addr);
  endtask

  initial begin
    exp_t e;
    int   x, y;

    rst      = 1'b1;
    pixel_en = 1'b0;
    cycle    = '0;
    scanline = '0;
`ifdef TILE_SCROLL_EN
    scroll_x = '0;
    scroll_y = '0;
`endif
    for (int i = 0; i < RAM_SIZE; i++) ram[i] = 8'($urandom);
    ram['h0051] = 8'h05;
    ram['h2051] = 8'hA3;
    ram['h402A] = 8'h80;
    exp_addr = '0;
    exp_pix  = '0;

    repeat (3) tick();
    check("rst_addr", mem_rd_addr, 0);
    check("rst_pix", pixel_data, 0);
    check("rst_valid", pixel_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick();

    // Directed lookups with known RAM contents.
    do_pixel(8, 10);
    check("t1_pat_addr_lit", mem_rd_addr, 'h402A);
    check("t1_pix_lit", pixel_data, 'h0A);
    do_pixel(9, 10);
    check("t2_pix_lit", pixel_data, 'h03);
    do_pixel(640, 0);
    check("t3_pix_lit", pixel_data, 'h00);
    check("t3_addr_held", mem_rd_addr, 'h402A);

    // Second strobe two cycles into a fetch is ignored and flags overrun.
    e = model(16, 20);
    pixel_en = 1'b1;
    cycle    = 10'd16;
    scanline = 9'd20;
    tick();
    pixel_en = 1'b0;
    check("ovr_pre", overrun, 0);
    tick();
    pixel_en = 1'b1;
    cycle    = 10'd100;
    scanline = 9'd100;
    tick();
    pixel_en = 1'b0;
    check("ovr_set", overrun, 1);
    check("ovr_addr_pat", mem_rd_addr, e.pat_a);
    tick();
    check("ovr_valid_t3", pixel_valid, 0);
    tick();
    exp_addr = e.pat_a;
    exp_pix  = e.pix;
    check("ovr_valid_t4", pixel_valid, 1);
    check("ovr_pix", pixel_data, exp_pix);
    do_pixel(24, 20);
    check("ovr_sticky", overrun, 1);

    // Reset in the middle of a fetch discards it.
    pixel_en = 1'b1;
    cycle    = 10'd40;
    scanline = 9'd30;
    tick();
    pixel_en = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_addr", mem_rd_addr, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    check("mid_rst_pix", pixel_data, 0);
    check("mid_rst_valid", pixel_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    rst = 1'b0;
    exp_addr = '0;
    exp_pix  = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_no_pulse", pixel_valid, 0);
    end
    do_pixel(8, 10);
    check("post_rst_pix", pixel_data, 'h0A);
    check("post_rst_overrun", overrun, 0);

    // Active-area boundaries.
    do_pixel(639, 479);
    do_pixel(0, 0);
    do_pixel(639, 480);
    do_pixel(0, 479);
    do_pixel(1023, 511);

`ifdef TILE_SCROLL_EN
    scroll_x = 10'd8;
    scroll_y = 9'd0;
    do_pixel(632, 10);
    check("scroll_x_map", mem_rd_addr, model(632, 10).pat_a);
    pixel_en = 1'b1;
    cycle    = 10'd632;
    scanline = 9'd10;
    tick();
    pixel_en = 1'b0;
    check("scroll_x_map_lit", mem_rd_addr, 'h0050);
    repeat (4) tick();
    scroll_y = 9'd470;
    pixel_en = 1'b1;
    tick();
    pixel_en = 1'b0;
    check("scroll_y_map_lit", mem_rd_addr, 'h0000);
    repeat (4) tick();
    exp_addr = mem_rd_addr;
    exp_pix  = model(632, 10).pix;
    check("scroll_y_pix", pixel_data, exp_pix);
`endif

    // Randomized pixels, mostly in the active area.
    for (int n = 0; n < 60; n++) begin
`ifdef TILE_SCROLL_EN
      scroll_x = 10'($urandom);
      scroll_y = 9'($urandom);
`endif
      if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 1023));
      else                           x = int'($urandom_range(0, H_ACTIVE - 1));
      if ($urandom_range(0, 3) == 0) y = int'($urandom_range(0, 511));
      else                           y = int'($urandom_range(0, V_ACTIVE - 1));
      do_pixel(x, y);
    end
    check("final_overrun", overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
